// File: rtl/dev_ram_streamer.sv
// dev_ram_streamer: byte-stream initiator for the dev_ram port.
// Write commands pack an incoming byte stream into RAM stores. Read commands
// unpack RAM loads into an outgoing byte stream. Aligned runs of 8 or more
// bytes use quad accesses. Unaligned heads and short tails use byte accesses.
// Byte order within a quad is big-endian: offset 0 is bits [63:56].

package pkg_ram;
    localparam int RAM_ADDRW = 17;

    typedef enum logic [1:0] {
        RAM_NOP   = 2'd0,
        RAM_LOAD  = 2'd1,
        RAM_STORE = 2'd2
    } ram_op_e;

    typedef enum logic [1:0] {
        RAM_BYTE = 2'd0,
        RAM_WORD = 2'd1,
        RAM_LONG = 2'd2,
        RAM_QUAD = 2'd3
    } ram_size_e;
endpackage

module dev_ram_streamer #(
    parameter int LEN_W = 17
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [pkg_ram::RAM_ADDRW-1:0] cmd_addr,
    input  logic [LEN_W-1:0]              cmd_len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_data,
    output logic                          done,
    output pkg_ram::ram_op_e              ram_op,
    output pkg_ram::ram_size_e            ram_size,
    output logic [pkg_ram::RAM_ADDRW-1:0] ram_addr,
    output logic [63:0]                   ram_data_in,
    input  logic [63:0]                   ram_data_out
);
    import pkg_ram::*;

    localparam int AW = RAM_ADDRW;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WR_COLLECT = 3'd1,
        S_WR_STORE   = 3'd2,
        S_RD_ISSUE   = 3'd3,
        S_RD_CAPTURE = 3'd4,
        S_RD_EMIT    = 3'd5,
        S_FINISH     = 3'd6
    } state_e;

    // A chunk is a quad only when the address is 8-byte aligned and at least
    // 8 bytes remain. Everything else goes out one byte at a time.
    function automatic logic chunk_is_quad(input logic [AW-1:0] a,
                                           input logic [LEN_W-1:0] r);
        return (a[2:0] == 3'd0) && (r >= LEN_W'(8));
    endfunction

    // Control and datapath state.
    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;     // start address of the current chunk
    logic [LEN_W-1:0] rem_q, rem_d;      // bytes left, including current chunk
    logic [63:0]     buf_q, buf_d;       // collect / emit buffer
    logic [3:0]      cnt_q, cnt_d;       // bytes done within the current chunk

    // Registered outputs.
    logic            cmd_ready_q, cmd_ready_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            done_q, done_d;
    ram_op_e         ram_op_q, ram_op_d;
    ram_size_e       ram_size_q, ram_size_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [63:0]     ram_data_in_q, ram_data_in_d;

    // Helpers for the chunk in progress and for the chunk being entered.
    logic            cur_quad_s;
    logic [3:0]      cur_len_s;
    logic [AW-1:0]   cur_astep_s;
    logic [LEN_W-1:0] cur_rstep_s;
    logic            nxt_quad_s;
    logic [63:0]     emit_shift_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        buf_d         = buf_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = 1'b0;
        in_ready_d    = 1'b0;
        out_valid_d   = 1'b0;
        out_data_d    = out_data_q;
        done_d        = 1'b0;
        ram_op_d      = RAM_NOP;
        ram_size_d    = ram_size_q;
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;

        cur_quad_s  = chunk_is_quad(addr_q, rem_q);
        cur_len_s   = cur_quad_s ? 4'd8 : 4'd1;
        cur_astep_s = cur_quad_s ? AW'(8) : AW'(1);
        cur_rstep_s = cur_quad_s ? LEN_W'(8) : LEN_W'(1);

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    cnt_d  = 4'd0;
                    if (cmd_len == LEN_W'(0)) begin
                        state_d = S_FINISH;
                    end else if (cmd_write) begin
                        state_d = S_WR_COLLECT;
                    end else begin
                        state_d = S_RD_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_COLLECT: begin
                if (in_valid && in_ready_q) begin
                    buf_d = {buf_q[55:0], in_data};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == cur_len_s) begin
                        state_d = S_WR_STORE;
                    end else begin
                        state_d = S_WR_COLLECT;
                    end
                end else begin
                    state_d = S_WR_COLLECT;
                end
            end
            S_WR_STORE: begin
                addr_d = addr_q + cur_astep_s;
                rem_d  = rem_q - cur_rstep_s;
                cnt_d  = 4'd0;
                if (rem_d == LEN_W'(0)) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_WR_COLLECT;
                end
            end
            S_RD_ISSUE: begin
                cnt_d   = 4'd0;
                state_d = S_RD_CAPTURE;
            end
            S_RD_CAPTURE: begin
                buf_d   = ram_data_out;
                cnt_d   = 4'd0;
                state_d = S_RD_EMIT;
            end
            S_RD_EMIT: begin
                if (out_valid_q && out_ready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == cur_len_s) begin
                        addr_d = addr_q + cur_astep_s;
                        rem_d  = rem_q - cur_rstep_s;
                        cnt_d  = 4'd0;
                        if (rem_d == LEN_W'(0)) begin
                            state_d = S_FINISH;
                        end else begin
                            state_d = S_RD_ISSUE;
                        end
                    end else begin
                        state_d = S_RD_EMIT;
                    end
                end else begin
                    state_d = S_RD_EMIT;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being
        // entered and from the chunk that state will work on.
        nxt_quad_s   = chunk_is_quad(addr_d, rem_d);
        emit_shift_s = buf_d >> {(3'd7 - cnt_d[2:0]), 3'b000};

        case (state_d)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
            end
            S_WR_COLLECT: begin
                in_ready_d = 1'b1;
            end
            S_WR_STORE: begin
                ram_op_d      = RAM_STORE;
                ram_size_d    = nxt_quad_s ? RAM_QUAD : RAM_BYTE;
                ram_addr_d    = addr_d;
                ram_data_in_d = nxt_quad_s ? buf_d : {56'd0, buf_d[7:0]};
            end
            S_RD_ISSUE: begin
                ram_op_d   = RAM_LOAD;
                ram_size_d = nxt_quad_s ? RAM_QUAD : RAM_BYTE;
                ram_addr_d = addr_d;
            end
            S_RD_CAPTURE: begin
                // dev_ram's output mux follows op/size/addr, so hold them.
                ram_op_d = RAM_LOAD;
            end
            S_RD_EMIT: begin
                out_valid_d = 1'b1;
                out_data_d  = nxt_quad_s ? emit_shift_s[7:0] : buf_d[7:0];
            end
            S_FINISH: begin
                done_d = 1'b1;
            end
            default: begin
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            rem_q         <= '0;
            buf_q         <= 64'd0;
            cnt_q         <= 4'd0;
            cmd_ready_q   <= 1'b1;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'd0;
            done_q        <= 1'b0;
            ram_op_q      <= RAM_NOP;
            ram_size_q    <= RAM_BYTE;
            ram_addr_q    <= '0;
            ram_data_in_q <= 64'd0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            done_q        <= done_d;
            ram_op_q      <= ram_op_d;
            ram_size_q    <= ram_size_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign done        = done_q;
    assign ram_op      = ram_op_q;
    assign ram_size    = ram_size_q;
    assign ram_addr    = ram_addr_q;
    assign ram_data_in = ram_data_in_q;

endmodule

// File: tb/tb_dev_ram_streamer.sv
// Scoreboard bench for dev_ram_streamer: stimulus pushes expected stores and
// read bytes into queues; a negedge monitor pops and compares them, models
// the RAM and checks done timing and out_data stability under back-pressure.
module tb_dev_ram_streamer;
    import pkg_ram::*;

    localparam int LEN_W = 17;
    localparam int AW    = RAM_ADDRW;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [AW-1:0]    cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             done;
    ram_op_e          ram_op;
    ram_size_e        ram_size;
    logic [AW-1:0]    ram_addr;
    logic [63:0]      ram_data_in;
    logic [63:0]      ram_data_out;

    dev_ram_streamer #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .done(done), .ram_op(ram_op), .ram_size(ram_size), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    size;
        logic [AW-1:0] addr;
        logic [63:0]   data;
    } st_t;

    st_t        exp_st[$];
    logic [7:0] exp_by[$];
    logic [7:0] mem [0:(1<<AW)-1];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   load_cnt = 0;
    int   last_evt_cyc = 0;
    bit   chk_gap = 1'b1;
    bit   toggle_mode = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    ram_op_e prev_op = RAM_NOP;

    logic [7:0] t2img [24] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                               8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C,
                               8'h0D, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // RAM contents: zero everywhere, plus a known quad at 0x40.
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[32'h40 + i] = 8'h11 * (i + 1);
        ram_data_out = 64'd0;
    end

    // Consumer back-pressure: always ready, or toggling every cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = toggle_mode ? ~out_ready : 1'b1;
        end
    end

    // Monitor: RAM model plus scoreboard comparisons.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (ram_op == RAM_STORE) begin
                if (exp_st.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_store actual_addr=%h required=no_store", ram_addr);
                end else begin
                    st_t e;
                    e = exp_st.pop_front();
                    check("store_size", ram_size, e.size);
                    check("store_addr", ram_addr, e.addr);
                    if (e.size == RAM_BYTE) check("store_byte", ram_data_in[7:0], e.data[7:0]);
                    else check("store_quad", ram_data_in, e.data);
                end
                if (ram_size == RAM_QUAD) begin
                    for (int i = 0; i < 8; i++) begin
                        logic [AW-1:0] ai;
                        ai = ram_addr + AW'(i);
                        mem[ai] = ram_data_in[63 - 8*i -: 8];
                    end
                end else begin
                    mem[ram_addr] = ram_data_in[7:0];
                end
                last_evt_cyc = cyc;
            end
            if (ram_op == RAM_LOAD && prev_op != RAM_LOAD) load_cnt++;
            if (ram_op == RAM_LOAD) begin
                logic [63:0] rd;
                rd = 64'd0;
                if (ram_size == RAM_QUAD) begin
                    for (int i = 0; i < 8; i++) begin
                        logic [AW-1:0] ai;
                        ai = ram_addr + AW'(i);
                        rd = {rd[55:0], mem[ai]};
                    end
                end else begin
                    rd = {56'd0, mem[ram_addr]};
                end
                ram_data_out = rd;
            end
            if (out_valid && prev_stall) check("out_data_stable", out_data, prev_data);
            if (out_valid && out_ready) begin
                if (exp_by.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=%h required=no_byte", out_data);
                end else begin
                    check("out_byte", out_data, exp_by.pop_front());
                end
                last_evt_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) begin
                done_cnt++;
                if (chk_gap) check("done_latency", cyc, last_evt_cyc + 1);
            end
            prev_op = ram_op;
        end else begin
            prev_stall = 1'b0;
            prev_op    = RAM_NOP;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ram_op"}, ram_op, RAM_NOP);
        check({tag, "_ram_size"}, ram_size, RAM_BYTE);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_ram_data_in"}, ram_data_in, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    // Offer a command until accepted (called #1 after a posedge).
    task automatic issue_cmd(input bit wr, input logic [AW-1:0] a, input logic [LEN_W-1:0] l);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        while (!cmd_ready && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept_timeout actual=busy required=ready");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Push n consecutive bytes starting at first into the write stream.
    task automatic send_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            k = 0;
            in_valid = 1'b1;
            in_data  = first + 8'(i);
            while (!in_ready && k < 500) begin
                @(posedge clk);
                #1;
                k++;
            end
            if (!in_ready) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout byte=%0d actual=0 required=1", i);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (done_cnt < target && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("done_count", done_cnt, target);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_vals("rst0");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Aligned quad write then read back.
        exp_st.push_back('{RAM_QUAD, 17'h00010, 64'h0102030405060708});
        issue_cmd(1'b1, 17'h00010, 17'd8);
        send_bytes(8'h01, 8);
        wait_done(1);
        for (int i = 0; i < 8; i++) exp_by.push_back(8'h01 + 8'(i));
        l0 = load_cnt;
        issue_cmd(1'b0, 17'h00010, 17'd8);
        wait_done(2);
        check("t1_loads", load_cnt - l0, 1);

        // Unaligned head, one quad, byte tail.
        for (int i = 0; i < 5; i++) exp_st.push_back('{RAM_BYTE, 17'(3 + i), 64'(i)});
        exp_st.push_back('{RAM_QUAD, 17'h00008, 64'h05060708090A0B0C});
        exp_st.push_back('{RAM_BYTE, 17'h00010, 64'h0D});
        issue_cmd(1'b1, 17'h00003, 17'd14);
        send_bytes(8'h00, 14);
        wait_done(3);
        for (int i = 0; i < 24; i++) exp_by.push_back(t2img[i]);
        l0 = load_cnt;
        issue_cmd(1'b0, 17'h00000, 17'd24);
        wait_done(4);
        check("t2_loads", load_cnt - l0, 3);

        // Read with out_ready toggling every cycle.
        toggle_mode = 1'b1;
        for (int i = 0; i < 8; i++) exp_by.push_back(8'h11 * 8'(i + 1));
        l0 = load_cnt;
        issue_cmd(1'b0, 17'h00040, 17'd8);
        wait_done(5);
        toggle_mode = 1'b0;
        check("t3_loads", load_cnt - l0, 1);

        // Zero-length write and read.
        chk_gap = 1'b0;
        l0 = load_cnt;
        issue_cmd(1'b1, 17'h00055, 17'd0);
        @(negedge clk);
        check("t4w_done", done, 1);
        check("t4w_ram_op", ram_op, RAM_NOP);
        @(negedge clk);
        check("t4w_cmd_ready", cmd_ready, 1);
        check("t4w_done_low", done, 0);
        @(posedge clk);
        #1;
        issue_cmd(1'b0, 17'h00066, 17'd0);
        @(negedge clk);
        check("t4r_done", done, 1);
        check("t4r_ram_op", ram_op, RAM_NOP);
        @(negedge clk);
        check("t4r_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        check("t4_done_count", done_cnt, 7);
        check("t4_loads", load_cnt - l0, 0);
        chk_gap = 1'b1;

        // Address wrap at the top of RAM.
        exp_st.push_back('{RAM_BYTE, 17'h1FFFE, 64'hE1});
        exp_st.push_back('{RAM_BYTE, 17'h1FFFF, 64'hE2});
        exp_st.push_back('{RAM_BYTE, 17'h00000, 64'hE3});
        exp_st.push_back('{RAM_BYTE, 17'h00001, 64'hE4});
        issue_cmd(1'b1, 17'h1FFFE, 17'd4);
        send_bytes(8'hE1, 4);
        wait_done(8);

        // Reset mid-write after 5 of 8 bytes, then a normal command.
        issue_cmd(1'b1, 17'h00020, 17'd8);
        send_bytes(8'hA0, 5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_mid");
        @(posedge clk);
        #1;
        check("t6_no_abort_done", done_cnt, 8);
        exp_st.push_back('{RAM_QUAD, 17'h00020, 64'hA0A1A2A3A4A5A6A7});
        issue_cmd(1'b1, 17'h00020, 17'd8);
        send_bytes(8'hA0, 8);
        wait_done(9);
        for (int i = 0; i < 8; i++) exp_by.push_back(8'hA0 + 8'(i));
        issue_cmd(1'b0, 17'h00020, 17'd8);
        wait_done(10);

        repeat (3) @(posedge clk);
        #1;
        check("store_queue_drained", exp_st.size(), 0);
        check("byte_queue_drained", exp_by.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
